// File: rtl/pcileech_com_rx_packer.sv
// pcileech_com_rx_packer
// Packs RATIO link words of IN_W bits into one OUT_W word and queues the packed words in a
// small first-word-fall-through (FWFT) FIFO. The first accepted link word lands in the MSBs.
//
// After reset the block runs a boot phase: it waits BOOT_DELAY cycles, then pushes BOOT_DEPTH
// static boot words before it starts taking link data. Two SYNC_WORDs accepted back to back
// realign the lane counter. A partial word left idle for PARTIAL_TIMEOUT cycles is discarded.
//
// Optional feature: define COM_RX_STATS_EN to build the stat_* counters. When it is not
// defined, the stat_* ports are tied to zero.
//
// Ports:
//   clk, rst      system clock; synchronous, active-high reset
//   boot_data     static boot words; word k = bits [k*OUT_W +: OUT_W]
//   in_data/in_valid/in_ready     link word input
//   out_data/out_valid/out_ready  FIFO head output (FWFT)
//   resync_pulse  one-cycle pulse after a resync
//   stat_words    packed words pushed (boot words excluded); wraps
//   stat_resyncs  resync events; saturates
//   stat_drops    partial words discarded by timeout; saturates
module pcileech_com_rx_packer #(
  parameter int unsigned IN_W            = 32,
  parameter int unsigned RATIO           = 2,
  parameter logic [IN_W-1:0] SYNC_WORD   = 32'h66665555,
  parameter int unsigned BOOT_DEPTH      = 5,
  parameter int unsigned BOOT_DELAY      = 16,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned PARTIAL_TIMEOUT = 1024,
  localparam int unsigned OUT_W          = IN_W * RATIO,
  localparam int unsigned BOOT_W         = (BOOT_DEPTH > 0) ? BOOT_DEPTH * OUT_W : OUT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BOOT_W-1:0] boot_data,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              resync_pulse,
  output logic [31:0]       stat_words,
  output logic [15:0]       stat_resyncs,
  output logic [15:0]       stat_drops
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned OCC_W  = CNT_W + 1;
  localparam int unsigned LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {StBootWait, StBootSend, StRun} state_e;

  state_e             state_q, state_d;
  logic [31:0]        delay_q, boot_idx_q, idle_q, idle_d;
  logic [LANE_W-1:0]  lane_q, lane_d;
  logic [OUT_W-1:0]   shreg_q, shreg_d, shreg_shift, boot_word, push_data;
  logic               pend_q, pend_d, prev_sync_q, prev_sync_d, resync_q, in_ready_q, in_ready_d;
  logic [OUT_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [OCC_W-1:0]   occ;
  logic               accept, is_sync, do_resync, last_lane, timeout;
  logic               boot_push, push, pop, full;

  assign accept    = in_valid & in_ready_q;
  assign is_sync   = (in_data == SYNC_WORD);
  assign do_resync = accept & is_sync & prev_sync_q;
  assign last_lane = (lane_q == LANE_W'(RATIO - 1));
  assign timeout   = (PARTIAL_TIMEOUT != 0) && !accept && (lane_q != '0) &&
                     (idle_q == 32'(PARTIAL_TIMEOUT - 1));
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign boot_word = boot_data[boot_idx_q * OUT_W +: OUT_W];

  if (RATIO > 1) begin : g_shift
    assign shreg_shift = {shreg_q[OUT_W-IN_W-1:0], in_data};
  end else begin : g_noshift
    assign shreg_shift = in_data;
  end

  // Boot sequencing FSM.
  always_comb begin
    state_d   = state_q;
    boot_push = 1'b0;
    unique case (state_q)
      StBootWait: begin
        if (BOOT_DELAY == 0 || delay_q == 32'(BOOT_DELAY - 1)) begin
          state_d = (BOOT_DEPTH == 0) ? StRun : StBootSend;
        end
      end
      StBootSend: begin
        if (!full) begin
          boot_push = 1'b1;
          if (boot_idx_q == 32'(BOOT_DEPTH - 1)) state_d = StRun;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StBootWait;
    endcase
  end

  // Packing, resync and partial-word timeout.
  always_comb begin
    lane_d      = lane_q;
    shreg_d     = shreg_q;
    pend_d      = 1'b0;
    prev_sync_d = prev_sync_q;
    idle_d      = 32'd0;
    if (accept) begin
      if (do_resync) begin
        lane_d      = '0;
        prev_sync_d = 1'b0;
      end else begin
        shreg_d     = shreg_shift;
        prev_sync_d = is_sync;
        if (last_lane) begin
          lane_d = '0;
          pend_d = 1'b1;
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end
    end else if (timeout) begin
      lane_d      = '0;
      prev_sync_d = 1'b0;
    end else if (lane_q != '0 && PARTIAL_TIMEOUT != 0) begin
      idle_d = idle_q + 32'd1;
    end
  end

  // FIFO control. A completed word is pushed the cycle after its last lane is accepted.
  always_comb begin
    push      = boot_push | pend_q;
    push_data = boot_push ? boot_word : shreg_q;
    pop       = out_ready & (count_q != '0);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Occupancy ignores this cycle's pop and includes the push still in flight, so a
    // pending word always finds room.
    occ        = OCC_W'(count_q) + OCC_W'(push) + OCC_W'(pend_d);
    in_ready_d = (state_d == StRun) && (occ < OCC_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBootWait;
      delay_q     <= 32'd0;
      boot_idx_q  <= 32'd0;
      idle_q      <= 32'd0;
      lane_q      <= '0;
      shreg_q     <= '0;
      pend_q      <= 1'b0;
      prev_sync_q <= 1'b0;
      resync_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      if (state_q == StBootWait) delay_q <= delay_q + 32'd1;
      if (boot_push) boot_idx_q <= boot_idx_q + 32'd1;
      idle_q      <= idle_d;
      lane_q      <= lane_d;
      shreg_q     <= shreg_d;
      pend_q      <= pend_d;
      prev_sync_q <= prev_sync_d;
      resync_q    <= do_resync;
      in_ready_q  <= in_ready_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (count_q != '0);
  assign out_data     = mem[rd_ptr_q];
  assign resync_pulse = resync_q;

`ifdef COM_RX_STATS_EN
  logic [31:0] words_q;
  logic [15:0] resyncs_q, drops_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q   <= 32'd0;
      resyncs_q <= 16'd0;
      drops_q   <= 16'd0;
    end else begin
      if (pend_q) words_q <= words_q + 32'd1;
      if (do_resync && resyncs_q != 16'hFFFF) resyncs_q <= resyncs_q + 16'd1;
      if (timeout && drops_q != 16'hFFFF) drops_q <= drops_q + 16'd1;
    end
  end

  assign stat_words   = words_q;
  assign stat_resyncs = resyncs_q;
  assign stat_drops   = drops_q;
`else
  assign stat_words   = 32'd0;
  assign stat_resyncs = 16'd0;
  assign stat_drops   = 16'd0;
`endif

endmodule
